step_ctrl: RTL

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/step_ctrl.sv
// Single-step / run controller for a soft CPU: gates the pipeline clock enable
// from debounced button pulses and counts the cycles the core actually executed.
module step_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_p_i,
    input  logic             run_p_i,
    input  logic             clr_p_i,
    input  logic [3:0]       burst_i,
    input  logic             halt_req_i,
    output logic             cpu_en_o,
    output logic             running_o,
    output logic             step_done_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // rem_q holds the enabled cycles still to come after the current one.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (halt_req_i) begin
                    state_d = S_IDLE;
                end else if (run_p_i) begin
                    state_d = S_RUN;
                end else if (step_p_i) begin
                    state_d = S_STEP;
                    rem_d   = burst_i;
                end
            end
            S_STEP: begin
                if (halt_req_i) begin
                    state_d = S_IDLE;
                    rem_d   = 4'd0;
                end else if (run_p_i) begin
                    state_d = S_RUN;
                    rem_d   = 4'd0;
                end else if (rem_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_q - 4'd1;
                end
            end
            S_RUN: begin
                if (halt_req_i || run_p_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = 4'd0;
            end
        endcase
    end

    // Completion is withheld when a halt or run toggle abandons the final cycle.
    always_comb begin
        cpu_en_o    = (state_q == S_STEP) || (state_q == S_RUN);
        running_o   = (state_q == S_RUN);
        step_done_o = (state_q == S_STEP) && (rem_q == 4'd0) && !halt_req_i && !run_p_i;
        state_o     = state_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_p_i) begin
            cnt_d = '0;
        end else if (cpu_en_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cyc_cnt_o = cnt_q;

endmodule
